rv32_decode_stage: RTL and testbench
====================================

Name: rv32_decode_stage

Overview:
- Pipelined RV32 instruction decoder; the producer side of the execution-unit operation encoding.
- Accepts raw 32-bit instruction words from fetch and emits one `exu_operation_t`, a target-unit select, register indices and a sign-extended immediate per instruction.
- Sits between fetch and issue/dispatch.
- Covers RV32I, M, and the Zba/Zbb/Zbs subset; integer loads/stores go to MEM. F-extension encodings are flagged illegal.

Parameters:
- XLEN, 32, datapath/immediate width; only 32 is supported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard all buffered and incoming instructions.
- instr_valid_i  in  1  instruction word valid.
- instr_ready_o  out  1  stage can accept an instruction.
- instr_i  in  32  instruction word.
- pc_i  in  32  PC of instr_i.
- dec_valid_o  out  1  decoded bundle valid.
- dec_ready_i  in  1  downstream accepts the bundle.
- op_o  out  `$bits(exu_operation_t)`  operation; only the field selected by unit_o is meaningful, all other fields are 0.
- unit_o  out  3  `exu_unit_t`: target unit.
- rd_o, rs1_o, rs2_o  out  5 each  register indices; forced to 0 when the format does not use them.
- imm_o  out  32  sign-extended immediate (I/S/B/U/J); shamt zero-extended; 0 for R-type.
- pc_o  out  32  PC passthrough.
- illegal_o  out  1  unsupported or illegal encoding.

Behaviour:
- Reset (rst_i high at an edge):
  - dec_valid_o=0, both buffer entries invalid, instr_ready_o=1 the following cycle.
  - op_o, unit_o, rd/rs1/rs2, imm_o, pc_o and illegal_o reset to 0.
  - Reset mid-stream drops all pending instructions.
- Handshakes:
  - Input handshake: instr_valid_i & instr_ready_o at an edge.
  - Output handshake: dec_valid_o & dec_ready_i at an edge.
  - dec_valid_o and all bundle outputs are stable while dec_valid_o=1 and dec_ready_i=0.
- Latency: an instruction accepted at edge N is visible on outputs after edge N (1 cycle) when the output register is free.
- Buffering: output register plus one skid entry.
  - instr_ready_o = !skid_valid, registered; there is no combinational path from dec_ready_i.
  - Output stalled and input handshake occurs: the decoded word goes to skid.
  - Output handshake occurs while skid is valid: skid moves to output and skid clears.
  - Input and output handshake in the same cycle with skid empty: the new word goes directly to output.
  - Order is always preserved; no bubbles when dec_ready_i is held at 1.
- Flush:
  - flush_i=1 at an edge invalidates output and skid; an input handshaked in the same cycle is discarded.
  - dec_valid_o=0 and instr_ready_o=1 next cycle.
  - Flush has priority over all handshakes; reset has priority over flush.
- Decode: purely combinational on the input side, registered once.
  - opcode 0110111/0010111 → ALU LUI/AUIPC, U-imm.
  - 1101111 → JAL, J-imm.
  - 1100111 with f3=000 → JALR.
  - 1100011 → BEQ/BNE/BLT/BGE/BLTU/BGEU by f3; f3 010/011 illegal.
  - 0000011 → MEM LB/LH/LW/LBU/LHU.
  - 0100011 → MEM SB/SH/SW.
  - 0010011/0110011 with f7=0000000 or 0100000 → ALU ops per funct3/funct7.
  - 0110011 with f7=0000001 → MUL (f3 0–3) or DIV (f3 4–7: DIV, DIVU, REM, REMU).
  - f7 0010000 with f3 010/100/110 → SH1ADD/SH2ADD/SH3ADD.
  - f7 0100000 with f3 111/110/100 → ANDN/ORN/XNOR.
  - f7 0000101 → MIN/MINU/MAX/MAXU.
  - f7 0110000 → ROL/ROR/RORI, and CLZ/CTZ/CPOP/SEXTB/SEXTH by rs2 field.
  - f7 0100100 → BCLR/BEXT; f7 0110100 → BINV; f7 0010100 → BSET, plus the I-variants.
  - ORCB = 0x28705013 pattern; REV8 = 0x69805013 pattern; ZEXTH = opcode 0110011, f7 0000100, rs2=0, f3=100.
- Shift-immediates with imm[5]=1 are illegal.
- Illegal instruction:
  - unit_o=UNIT_NONE, op_o=0, illegal_o=1, pc_o valid.
  - It still flows through the handshake like any instruction.
- F opcodes (0000111, 0100111, 1000011–1001111, 1010011) are illegal; FENCE/SYSTEM are also illegal in this block.

Decomposition:
- Add to the shared instruction package:
  - `exu_unit_t` enum {UNIT_ALU, UNIT_BMU, UNIT_MUL, UNIT_DIV, UNIT_MEM, UNIT_NONE}. Literal names must not collide with operation literals.
  - Opcode constants as localparams.
  - A `decoded_bundle_t` struct {op, unit, rd, rs1, rs2, imm, pc, illegal}.
- Sub-module rv32_decoder_comb: pure combinational instr→decoded_bundle_t.
- The top module holds the output register, skid buffer and handshake control.

Test Plan:
- ADDI x1,x2,5 (0x00510093), ready_i=1 → next cycle: dec_valid=1, unit=UNIT_ALU, op.ALU=ADDI, rd=1, rs1=2, imm=5, illegal=0.
- MULHU x3,x4,x5 (0x025231B3) → unit=UNIT_MUL, op.MUL=MULHU, rd=3, rs1=4, rs2=5, imm=0.
- CLZ x1,x2 (0x60011093) → unit=UNIT_BMU, op.BMU=CLZ. Also 0x00000000 → illegal_o=1, unit=UNIT_NONE.
- Backpressure: dec_ready_i=0 for 3 cycles while offering 3 instructions → instr_ready_o drops after 2 are accepted, outputs hold, then 3 bundles drain in order with no loss or duplication.
- Flush with skid full and an input handshake in the same cycle → dec_valid_o=0 next cycle, instr_ready_o=1, the first post-flush instruction emerges 1 cycle after acceptance.
- Synchronous reset asserted mid-stream with valid output → all outputs 0 after the edge; an instruction offered during reset is not accepted.

Source files
------------

// File: rtl/rv32_decode_stage_pkg.sv
// Shared RV32 decode types: execution-unit operation encoding, unit select,
// opcode constants and the decoded bundle handed from decode to issue.
package rv32_decode_stage_pkg;

    localparam int DEC_XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        UNIT_ALU = 3'd0, UNIT_BMU, UNIT_MUL, UNIT_DIV, UNIT_MEM, UNIT_NONE
    } exu_unit_t;

    // Each per-unit code uses 0 as "no operation" so unused fields read as 0
    typedef enum logic [4:0] {
        ALU_NOP = 5'd0, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ADDI, ALU_SLTI, ALU_SLTIU,
        ALU_XORI, ALU_ORI, ALU_ANDI, ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_LUI,
        ALU_AUIPC, ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE,
        ALU_BLTU, ALU_BGEU
    } alu_op_t;

    typedef enum logic [4:0] {
        BMU_NOP = 5'd0, BMU_SH1ADD, BMU_SH2ADD, BMU_SH3ADD, BMU_ANDN, BMU_ORN,
        BMU_XNOR, BMU_CLZ, BMU_CTZ, BMU_CPOP, BMU_SEXTB, BMU_SEXTH, BMU_ZEXTH,
        BMU_MIN, BMU_MINU, BMU_MAX, BMU_MAXU, BMU_ROL, BMU_ROR, BMU_RORI,
        BMU_ORCB, BMU_REV8, BMU_BCLR, BMU_BCLRI, BMU_BEXT, BMU_BEXTI,
        BMU_BINV, BMU_BINVI, BMU_BSET, BMU_BSETI
    } bmu_op_t;

    typedef enum logic [2:0] {
        MUL_NOP = 3'd0, MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU
    } mul_op_t;

    typedef enum logic [2:0] {
        DIV_NOP = 3'd0, DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU
    } div_op_t;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
        MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;

    // Operand format: selects which register fields and immediate are live
    typedef enum logic [3:0] {
        FMT_NONE = 4'd0, FMT_R, FMT_I, FMT_SH, FMT_UN, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_t;

    typedef struct packed {
        alu_op_t alu;
        bmu_op_t bmu;
        mul_op_t mul;
        div_op_t div;
        mem_op_t mem;
    } exu_operation_t;

    typedef struct packed {
        exu_operation_t      op;
        exu_unit_t           unit;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [DEC_XLEN-1:0] imm;
        logic [DEC_XLEN-1:0] pc;
        logic                illegal;
    } decoded_bundle_t;

endpackage

// File: rtl/rv32_decoder_comb.sv
// Combinational RV32IM + Zba/Zbb/Zbs decoder: raw instruction word to bundle.
// Anything without a recognised operation comes out as UNIT_NONE / illegal.
module rv32_decoder_comb
    import rv32_decode_stage_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [DEC_XLEN-1:0] pc,
    output decoded_bundle_t     dec
);

    logic [6:0]  opcode_s, f7_s;
    logic [2:0]  f3_s;
    logic [4:0]  rs2f_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;
    alu_op_t     alu_s;
    bmu_op_t     bmu_s;
    mul_op_t     mul_s;
    div_op_t     div_s;
    mem_op_t     mem_s;
    fmt_t        fmt_s;
    exu_unit_t   unit_s;

    assign opcode_s = instr[6:0];
    assign f3_s     = instr[14:12];
    assign f7_s     = instr[31:25];
    assign rs2f_s   = instr[24:20];
    assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s  = {instr[31:12], 12'd0};
    assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt_s  = {27'd0, instr[24:20]};

    // Opcode/funct decode into per-unit operation codes and an operand format
    always_comb begin
        alu_s = ALU_NOP;
        bmu_s = BMU_NOP;
        mul_s = MUL_NOP;
        div_s = DIV_NOP;
        mem_s = MEM_NOP;
        fmt_s = FMT_NONE;
        case (opcode_s)
            OPC_LUI:   begin alu_s = ALU_LUI;   fmt_s = FMT_U; end
            OPC_AUIPC: begin alu_s = ALU_AUIPC; fmt_s = FMT_U; end
            OPC_JAL:   begin alu_s = ALU_JAL;   fmt_s = FMT_J; end
            OPC_JALR: begin
                fmt_s = FMT_I;
                if (f3_s == 3'b000) alu_s = ALU_JALR;
                else                alu_s = ALU_NOP;
            end
            OPC_BRANCH: begin
                fmt_s = FMT_B;
                case (f3_s)
                    3'b000:  alu_s = ALU_BEQ;
                    3'b001:  alu_s = ALU_BNE;
                    3'b100:  alu_s = ALU_BLT;
                    3'b101:  alu_s = ALU_BGE;
                    3'b110:  alu_s = ALU_BLTU;
                    3'b111:  alu_s = ALU_BGEU;
                    default: alu_s = ALU_NOP;
                endcase
            end
            OPC_LOAD: begin
                fmt_s = FMT_I;
                case (f3_s)
                    3'b000:  mem_s = MEM_LB;
                    3'b001:  mem_s = MEM_LH;
                    3'b010:  mem_s = MEM_LW;
                    3'b100:  mem_s = MEM_LBU;
                    3'b101:  mem_s = MEM_LHU;
                    default: mem_s = MEM_NOP;
                endcase
            end
            OPC_STORE: begin
                fmt_s = FMT_S;
                case (f3_s)
                    3'b000:  mem_s = MEM_SB;
                    3'b001:  mem_s = MEM_SH;
                    3'b010:  mem_s = MEM_SW;
                    default: mem_s = MEM_NOP;
                endcase
            end
            OPC_OPIMM: begin
                fmt_s = FMT_I;
                case (f3_s)
                    3'b000: alu_s = ALU_ADDI;
                    3'b010: alu_s = ALU_SLTI;
                    3'b011: alu_s = ALU_SLTIU;
                    3'b100: alu_s = ALU_XORI;
                    3'b110: alu_s = ALU_ORI;
                    3'b111: alu_s = ALU_ANDI;
                    // Exact funct7 match also rejects shamt[5]=1 on RV32
                    3'b001: begin
                        fmt_s = FMT_SH;
                        case (f7_s)
                            7'b0000000: alu_s = ALU_SLLI;
                            7'b0010100: bmu_s = BMU_BSETI;
                            7'b0100100: bmu_s = BMU_BCLRI;
                            7'b0110100: bmu_s = BMU_BINVI;
                            7'b0110000: begin
                                fmt_s = FMT_UN;
                                case (rs2f_s)
                                    5'b00000: bmu_s = BMU_CLZ;
                                    5'b00001: bmu_s = BMU_CTZ;
                                    5'b00010: bmu_s = BMU_CPOP;
                                    5'b00100: bmu_s = BMU_SEXTB;
                                    5'b00101: bmu_s = BMU_SEXTH;
                                    default:  bmu_s = BMU_NOP;
                                endcase
                            end
                            default: alu_s = ALU_NOP;
                        endcase
                    end
                    3'b101: begin
                        fmt_s = FMT_SH;
                        case (f7_s)
                            7'b0000000: alu_s = ALU_SRLI;
                            7'b0100000: alu_s = ALU_SRAI;
                            7'b0110000: bmu_s = BMU_RORI;
                            7'b0100100: bmu_s = BMU_BEXTI;
                            7'b0010100: begin
                                fmt_s = FMT_UN;
                                if (rs2f_s == 5'b00111) bmu_s = BMU_ORCB;
                                else                    bmu_s = BMU_NOP;
                            end
                            7'b0110100: begin
                                fmt_s = FMT_UN;
                                if (rs2f_s == 5'b11000) bmu_s = BMU_REV8;
                                else                    bmu_s = BMU_NOP;
                            end
                            default: alu_s = ALU_NOP;
                        endcase
                    end
                    default: alu_s = ALU_NOP;
                endcase
            end
            OPC_OP: begin
                fmt_s = FMT_R;
                case (f7_s)
                    7'b0000000: begin
                        case (f3_s)
                            3'b000:  alu_s = ALU_ADD;
                            3'b001:  alu_s = ALU_SLL;
                            3'b010:  alu_s = ALU_SLT;
                            3'b011:  alu_s = ALU_SLTU;
                            3'b100:  alu_s = ALU_XOR;
                            3'b101:  alu_s = ALU_SRL;
                            3'b110:  alu_s = ALU_OR;
                            default: alu_s = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3_s)
                            3'b000:  alu_s = ALU_SUB;
                            3'b101:  alu_s = ALU_SRA;
                            3'b111:  bmu_s = BMU_ANDN;
                            3'b110:  bmu_s = BMU_ORN;
                            3'b100:  bmu_s = BMU_XNOR;
                            default: alu_s = ALU_NOP;
                        endcase
                    end
                    7'b0000001: begin
                        case (f3_s)
                            3'b000:  mul_s = MUL_MUL;
                            3'b001:  mul_s = MUL_MULH;
                            3'b010:  mul_s = MUL_MULHSU;
                            3'b011:  mul_s = MUL_MULHU;
                            3'b100:  div_s = DIV_DIV;
                            3'b101:  div_s = DIV_DIVU;
                            3'b110:  div_s = DIV_REM;
                            default: div_s = DIV_REMU;
                        endcase
                    end
                    7'b0010000: begin
                        case (f3_s)
                            3'b010:  bmu_s = BMU_SH1ADD;
                            3'b100:  bmu_s = BMU_SH2ADD;
                            3'b110:  bmu_s = BMU_SH3ADD;
                            default: bmu_s = BMU_NOP;
                        endcase
                    end
                    7'b0000101: begin
                        case (f3_s)
                            3'b100:  bmu_s = BMU_MIN;
                            3'b101:  bmu_s = BMU_MINU;
                            3'b110:  bmu_s = BMU_MAX;
                            3'b111:  bmu_s = BMU_MAXU;
                            default: bmu_s = BMU_NOP;
                        endcase
                    end
                    7'b0110000: begin
                        case (f3_s)
                            3'b001:  bmu_s = BMU_ROL;
                            3'b101:  bmu_s = BMU_ROR;
                            default: bmu_s = BMU_NOP;
                        endcase
                    end
                    7'b0100100: begin
                        case (f3_s)
                            3'b001:  bmu_s = BMU_BCLR;
                            3'b101:  bmu_s = BMU_BEXT;
                            default: bmu_s = BMU_NOP;
                        endcase
                    end
                    7'b0110100: begin
                        if (f3_s == 3'b001) bmu_s = BMU_BINV;
                        else                bmu_s = BMU_NOP;
                    end
                    7'b0010100: begin
                        if (f3_s == 3'b001) bmu_s = BMU_BSET;
                        else                bmu_s = BMU_NOP;
                    end
                    7'b0000100: begin
                        if (f3_s == 3'b100 && rs2f_s == 5'd0) bmu_s = BMU_ZEXTH;
                        else                                  bmu_s = BMU_NOP;
                    end
                    default: alu_s = ALU_NOP;
                endcase
            end
            default: fmt_s = FMT_NONE;
        endcase
    end

    // At most one per-unit code is non-zero; that one names the target unit
    always_comb begin
        if (alu_s != ALU_NOP)      unit_s = UNIT_ALU;
        else if (bmu_s != BMU_NOP) unit_s = UNIT_BMU;
        else if (mul_s != MUL_NOP) unit_s = UNIT_MUL;
        else if (div_s != DIV_NOP) unit_s = UNIT_DIV;
        else if (mem_s != MEM_NOP) unit_s = UNIT_MEM;
        else                       unit_s = UNIT_NONE;
    end

    // Bundle assembly: unused register fields and immediates forced to zero
    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.unit    = unit_s;
        dec.illegal = (unit_s == UNIT_NONE);
        if (unit_s != UNIT_NONE) begin
            dec.op = '{alu: alu_s, bmu: bmu_s, mul: mul_s, div: div_s, mem: mem_s};
            case (fmt_s)
                FMT_R:  begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.rs2 = rs2f_s; end
                FMT_I:  begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = imm_i_s; end
                FMT_SH: begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = shamt_s; end
                FMT_UN: begin dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; end
                FMT_S:  begin dec.rs1 = instr[19:15]; dec.rs2 = rs2f_s; dec.imm = imm_s_s; end
                FMT_B:  begin dec.rs1 = instr[19:15]; dec.rs2 = rs2f_s; dec.imm = imm_b_s; end
                FMT_U:  begin dec.rd = instr[11:7]; dec.imm = imm_u_s; end
                FMT_J:  begin dec.rd = instr[11:7]; dec.imm = imm_j_s; end
                default: dec.rd = 5'd0;
            endcase
        end else begin
            dec.op = '0;
        end
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: combinational decoder feeding an output register backed
// by one skid entry, so instr_ready_o never depends combinationally on dec_ready_i.
module rv32_decode_stage
    import rv32_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output exu_operation_t  op_o,
    output exu_unit_t       unit_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    decoded_bundle_t dec_s, out_r, skid_r, out_nxt_s, skid_nxt_s;
    logic            out_valid_r, skid_valid_r, ready_r;
    logic            out_valid_nxt_s, skid_valid_nxt_s;
    logic            in_hs_s, out_free_s;

    rv32_decoder_comb u_decoder (
        .instr (instr_i),
        .pc    (pc_i),
        .dec   (dec_s)
    );

    assign in_hs_s    = instr_valid_i & ready_r;
    assign out_free_s = ~out_valid_r | dec_ready_i;

    // Next state of output register and skid entry; skid always drains first
    always_comb begin
        out_nxt_s        = out_r;
        skid_nxt_s       = skid_r;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush_i) begin
            out_valid_nxt_s  = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_nxt_s        = skid_r;
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (in_hs_s) begin
                out_nxt_s       = dec_s;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (in_hs_s) begin
                skid_nxt_s       = dec_s;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Pipeline state with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_r        <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            out_r        <= out_nxt_s;
            skid_r       <= skid_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            ready_r      <= ~skid_valid_nxt_s;
        end
    end

    assign instr_ready_o = ready_r;
    assign dec_valid_o   = out_valid_r;
    assign op_o          = out_r.op;
    assign unit_o        = out_r.unit;
    assign rd_o          = out_r.rd;
    assign rs1_o         = out_r.rs1;
    assign rs2_o         = out_r.rs2;
    assign imm_o         = out_r.imm;
    assign pc_o          = out_r.pc;
    assign illegal_o     = out_r.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: decode vectors, backpressure, flush, reset.
module tb_rv32_decode_stage;
    import rv32_decode_stage_pkg::*;

    logic           clk = 1'b0;
    logic           rst, flush, instr_valid, instr_ready, dec_valid, dec_ready, illegal;
    logic [31:0]    instr, pc, pc_out, imm;
    logic [4:0]     rd, rs1, rs2;
    exu_operation_t op;
    exu_unit_t      unit;
    int             total = 0;
    int             bad = 0;

    rv32_decode_stage #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .pc_i(pc),
        .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
        .op_o(op), .unit_o(unit), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
        .imm_o(imm), .pc_o(pc_out), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
        total++;
        assert (got === req) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, req);
        end
    endtask

    function automatic exu_operation_t o_alu(input alu_op_t a);
        exu_operation_t o = '0; o.alu = a; return o;
    endfunction
    function automatic exu_operation_t o_bmu(input bmu_op_t b);
        exu_operation_t o = '0; o.bmu = b; return o;
    endfunction
    function automatic exu_operation_t o_mul(input mul_op_t m);
        exu_operation_t o = '0; o.mul = m; return o;
    endfunction
    function automatic exu_operation_t o_div(input div_op_t d);
        exu_operation_t o = '0; o.div = d; return o;
    endfunction
    function automatic exu_operation_t o_mem(input mem_op_t m);
        exu_operation_t o = '0; o.mem = m; return o;
    endfunction

    task automatic send(input logic [31:0] ins, input logic [31:0] p);
        instr_valid = 1'b1;
        instr = ins;
        pc = p;
        step();
    endtask

    task automatic chk_bundle(input string tag, input exu_unit_t u, input exu_operation_t o,
                              input logic [4:0] erd, input logic [4:0] ers1, input logic [4:0] ers2,
                              input logic [31:0] eimm, input logic [31:0] epc, input logic eill);
        chk({tag, ".valid"}, 32'(dec_valid), 32'd1);
        chk({tag, ".unit"}, 32'(unit), 32'(u));
        chk({tag, ".op"}, 32'(op), 32'(o));
        chk({tag, ".rd"}, 32'(rd), 32'(erd));
        chk({tag, ".rs1"}, 32'(rs1), 32'(ers1));
        chk({tag, ".rs2"}, 32'(rs2), 32'(ers2));
        chk({tag, ".imm"}, imm, eimm);
        chk({tag, ".pc"}, pc_out, epc);
        chk({tag, ".illegal"}, 32'(illegal), 32'(eill));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(dec_valid), 32'd0);
        chk({tag, ".ready"}, 32'(instr_ready), 32'd1);
        chk({tag, ".unit"}, 32'(unit), 32'd0);
        chk({tag, ".op"}, 32'(op), 32'd0);
        chk({tag, ".regs"}, {17'd0, rd, rs1, rs2}, 32'd0);
        chk({tag, ".imm"}, imm, 32'd0);
        chk({tag, ".pc"}, pc_out, 32'd0);
        chk({tag, ".illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b1;
        instr = 32'd0; pc = 32'd0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;

        // streaming decode with dec_ready held high
        send(32'h00510093, 32'h100); chk_bundle("addi",   UNIT_ALU,  o_alu(ALU_ADDI),   5'd1,  5'd2,  5'd0,  32'd5,        32'h100, 1'b0);
        send(32'h025231B3, 32'h104); chk_bundle("mulhu",  UNIT_MUL,  o_mul(MUL_MULHU),  5'd3,  5'd4,  5'd5,  32'd0,        32'h104, 1'b0);
        send(32'h60011093, 32'h108); chk_bundle("clz",    UNIT_BMU,  o_bmu(BMU_CLZ),    5'd1,  5'd2,  5'd0,  32'd0,        32'h108, 1'b0);
        send(32'h00000000, 32'h10C); chk_bundle("zero",   UNIT_NONE, '0,                5'd0,  5'd0,  5'd0,  32'd0,        32'h10C, 1'b1);
        send(32'hFE532E23, 32'h110); chk_bundle("sw",     UNIT_MEM,  o_mem(MEM_SW),     5'd0,  5'd6,  5'd5,  32'hFFFFFFFC, 32'h110, 1'b0);
        send(32'hFE208CE3, 32'h114); chk_bundle("beq",    UNIT_ALU,  o_alu(ALU_BEQ),    5'd0,  5'd1,  5'd2,  32'hFFFFFFF8, 32'h114, 1'b0);
        send(32'h123453B7, 32'h118); chk_bundle("lui",    UNIT_ALU,  o_alu(ALU_LUI),    5'd7,  5'd0,  5'd0,  32'h12345000, 32'h118, 1'b0);
        send(32'h001000EF, 32'h11C); chk_bundle("jal",    UNIT_ALU,  o_alu(ALU_JAL),    5'd1,  5'd0,  5'd0,  32'h00000800, 32'h11C, 1'b0);
        send(32'h4030D093, 32'h120); chk_bundle("srai",   UNIT_ALU,  o_alu(ALU_SRAI),   5'd1,  5'd1,  5'd0,  32'd3,        32'h120, 1'b0);
        send(32'h4210D093, 32'h124); chk_bundle("srai5",  UNIT_NONE, '0,                5'd0,  5'd0,  5'd0,  32'd0,        32'h124, 1'b1);
        send(32'h00002007, 32'h128); chk_bundle("flw",    UNIT_NONE, '0,                5'd0,  5'd0,  5'd0,  32'd0,        32'h128, 1'b1);
        send(32'hFFF12083, 32'h12C); chk_bundle("lw",     UNIT_MEM,  o_mem(MEM_LW),     5'd1,  5'd2,  5'd0,  32'hFFFFFFFF, 32'h12C, 1'b0);
        send(32'h28705013, 32'h130); chk_bundle("orcb",   UNIT_BMU,  o_bmu(BMU_ORCB),   5'd0,  5'd0,  5'd0,  32'd0,        32'h130, 1'b0);
        send(32'h69805013, 32'h134); chk_bundle("rev8",   UNIT_BMU,  o_bmu(BMU_REV8),   5'd0,  5'd0,  5'd0,  32'd0,        32'h134, 1'b0);
        send(32'h080140B3, 32'h138); chk_bundle("zexth",  UNIT_BMU,  o_bmu(BMU_ZEXTH),  5'd1,  5'd2,  5'd0,  32'd0,        32'h138, 1'b0);
        send(32'h02C5F533, 32'h13C); chk_bundle("remu",   UNIT_DIV,  o_div(DIV_REMU),   5'd10, 5'd11, 5'd12, 32'd0,        32'h13C, 1'b0);
        send(32'h203140B3, 32'h140); chk_bundle("sh2add", UNIT_BMU,  o_bmu(BMU_SH2ADD), 5'd1,  5'd2,  5'd3,  32'd0,        32'h140, 1'b0);
        send(32'h00000073, 32'h144); chk_bundle("ecall",  UNIT_NONE, '0,                5'd0,  5'd0,  5'd0,  32'd0,        32'h144, 1'b1);
        chk("stream.ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b0;
        step();
        chk("stream.drain", 32'(dec_valid), 32'd0);

        // backpressure: A to output, B to skid, C refused
        dec_ready = 1'b0;
        send(32'h00100093, 32'h200);
        chk("bp.a.rd", 32'(rd), 32'd1);
        chk("bp.a.ready", 32'(instr_ready), 32'd1);
        send(32'h00200113, 32'h204);
        chk("bp.b.ready", 32'(instr_ready), 32'd0);
        chk("bp.b.hold", 32'(rd), 32'd1);
        send(32'h00300193, 32'h208);
        chk("bp.c.ready", 32'(instr_ready), 32'd0);
        chk("bp.c.hold_valid", 32'(dec_valid), 32'd1);
        chk("bp.c.hold_pc", pc_out, 32'h200);
        dec_ready = 1'b1;
        step();
        chk_bundle("bp.out_b", UNIT_ALU, o_alu(ALU_ADDI), 5'd2, 5'd0, 5'd0, 32'd2, 32'h204, 1'b0);
        chk("bp.ready_back", 32'(instr_ready), 32'd1);
        step();
        chk_bundle("bp.out_c", UNIT_ALU, o_alu(ALU_ADDI), 5'd3, 5'd0, 5'd0, 32'd3, 32'h208, 1'b0);
        instr_valid = 1'b0;
        step();
        chk("bp.drained", 32'(dec_valid), 32'd0);

        // flush with skid full, then flush against a live input handshake
        dec_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200113, 32'h304);
        chk("fl.skid_full", 32'(instr_ready), 32'd0);
        flush = 1'b1;
        send(32'h00300193, 32'h308);
        chk("fl.valid", 32'(dec_valid), 32'd0);
        chk("fl.ready", 32'(instr_ready), 32'd1);
        send(32'h00300193, 32'h308);
        chk("fl.hs.valid", 32'(dec_valid), 32'd0);
        chk("fl.hs.ready", 32'(instr_ready), 32'd1);
        flush = 1'b0;
        dec_ready = 1'b1;
        send(32'h00400213, 32'h30C);
        chk_bundle("fl.post", UNIT_ALU, o_alu(ALU_ADDI), 5'd4, 5'd0, 5'd0, 32'd4, 32'h30C, 1'b0);
        instr_valid = 1'b0;
        step();
        chk("fl.drained", 32'(dec_valid), 32'd0);

        // synchronous reset mid-stream with a valid stalled output
        dec_ready = 1'b0;
        send(32'h00500293, 32'h400);
        chk("rs.pre_valid", 32'(dec_valid), 32'd1);
        rst = 1'b1;
        send(32'h00600313, 32'h404);
        chk_zero("rs.mid");
        step();
        rst = 1'b0;
        instr_valid = 1'b0;
        dec_ready = 1'b1;
        step();
        chk("rs.not_accepted", 32'(dec_valid), 32'd0);
        chk("rs.ready", 32'(instr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
